// File: rtl/mano_fetch_exec_sequencer_pkg.sv
// Shared types and constants for the accumulator-computer fetch/execute sequencer.
// Holds the FSM state encoding, opcode values and per-state decode helpers.
package mano_fetch_exec_sequencer_pkg;

  typedef enum logic [3:0] {
    IDLE,
    F_ADR,
    F_MEM,
    DEC,
    X_MOV,
    L_ADR,
    L_OPM,
    L_PTR,
    L_DATM,
    L_WB,
    PAUSE,
    HALTED
  } state_t;

  localparam logic [1:0] OP_NOP  = 2'b00;
  localparam logic [1:0] OP_LDA  = 2'b01;
  localparam logic [1:0] OP_MOVR = 2'b10;
  localparam logic [1:0] OP_HLT  = 2'b11;

  localparam int TIMEOUT_CYC_DEF = 15;

  // States that hold mem_req and wait on mem_ack independently of tick_en.
  function automatic logic is_mem_state(input state_t s);
    return (s == F_MEM) || (s == L_OPM) || (s == L_DATM);
  endfunction

  function automatic logic is_quiet_state(input state_t s);
    return (s == IDLE) || (s == PAUSE) || (s == HALTED);
  endfunction

  function automatic logic [2:0] t_step_of(input state_t s);
    logic [2:0] t;
    t = 3'd0;
    case (s)
      F_MEM:          t = 3'd1;
      DEC:            t = 3'd2;
      X_MOV, L_ADR:   t = 3'd3;
      L_OPM:          t = 3'd4;
      L_PTR:          t = 3'd5;
      L_DATM:         t = 3'd6;
      L_WB:           t = 3'd7;
      default:        t = 3'd0;
    endcase
    return t;
  endfunction

endpackage

// File: rtl/mano_fetch_exec_sequencer_mem_wait_timer.sv
// Counts clocks spent waiting for mem_ack; expired flags the last clock before a timeout.
// One instance is shared by all memory-wait states since they are never adjacent.
module mano_mem_wait_timer #(
  parameter int TIMEOUT_CYC = 15,
  parameter int TMO_W       = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic clear_i,
  input  logic count_en_i,
  input  logic ack_i,
  output logic expired_o
);

  localparam logic [TMO_W-1:0] LAST_CNT = TMO_W'(TIMEOUT_CYC - 1);

  logic [TMO_W-1:0] cnt_q;
  logic [TMO_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (count_en_i && !ack_i && (cnt_q != LAST_CNT)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Asserted during the clock that would bring the wait to TIMEOUT_CYC clocks.
  assign expired_o = count_en_i && (cnt_q == LAST_CNT);

endmodule

// File: rtl/mano_fetch_exec_sequencer.sv
// Single-clock fetch/decode/execute control FSM for the accumulator datapath.
// Emits one-clock load/increment strobes and handshakes reads with byte memory.
module mano_fetch_exec_sequencer
  import mano_fetch_exec_sequencer_pkg::*;
#(
  parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF,
  parameter int TMO_W       = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick_en,
  input  logic       run,
  input  logic       single_step,
  input  logic       step_req,
  input  logic [1:0] opcode,
  input  logic       mem_ack,
  output logic       mem_req,
  output logic       ld_mar_pc,
  output logic       ld_mar_mbr,
  output logic       inc_pc,
  output logic       ld_mbr,
  output logic       ld_ir,
  output logic       ld_a_mbr,
  output logic       ld_a_r,
  output logic [2:0] t_step,
  output logic       busy,
  output logic       instr_done,
  output logic       halted,
  output logic       bus_err
);

  state_t state_q;
  state_t state_d;
  state_t boundary_st;
  logic   bus_err_q;
  logic   bus_err_d;
  logic   in_mem_st;
  logic   tmo_expired;

  assign in_mem_st = is_mem_state(state_q);

  mano_mem_wait_timer #(
    .TIMEOUT_CYC (TIMEOUT_CYC),
    .TMO_W       (TMO_W)
  ) u_wait_timer (
    .clk        (clk),
    .rst        (rst),
    .clear_i    (!in_mem_st),
    .count_en_i (in_mem_st),
    .ack_i      (mem_ack),
    .expired_o  (tmo_expired)
  );

  // Where an instruction lands when it finishes; DONE is folded into this choice.
  always_comb begin
    boundary_st = F_ADR;
    if (!run) begin
      boundary_st = IDLE;
    end else if (single_step) begin
      boundary_st = PAUSE;
    end
  end

  always_comb begin
    state_d    = state_q;
    bus_err_d  = bus_err_q;
    mem_req    = 1'b0;
    ld_mar_pc  = 1'b0;
    ld_mar_mbr = 1'b0;
    inc_pc     = 1'b0;
    ld_mbr     = 1'b0;
    ld_ir      = 1'b0;
    ld_a_mbr   = 1'b0;
    ld_a_r     = 1'b0;
    instr_done = 1'b0;

    case (state_q)
      IDLE: begin
        if (tick_en && run) state_d = F_ADR;
      end
      F_ADR: begin
        if (tick_en) begin
          ld_mar_pc = 1'b1;
          state_d   = F_MEM;
        end
      end
      F_MEM: begin
        mem_req = 1'b1;
        if (mem_ack) begin
          ld_mbr  = 1'b1;
          inc_pc  = 1'b1;
          state_d = DEC;
        end else if (tmo_expired) begin
          bus_err_d = 1'b1;
          state_d   = HALTED;
        end
      end
      DEC: begin
        if (tick_en) begin
          ld_ir = 1'b1;
          case (opcode)
            OP_LDA:  state_d = L_ADR;
            OP_MOVR: state_d = X_MOV;
            OP_HLT: begin
              instr_done = 1'b1;
              state_d    = HALTED;
            end
            default: begin
              instr_done = 1'b1;
              state_d    = boundary_st;
            end
          endcase
        end
      end
      X_MOV: begin
        if (tick_en) begin
          ld_a_r     = 1'b1;
          instr_done = 1'b1;
          state_d    = boundary_st;
        end
      end
      L_ADR: begin
        if (tick_en) begin
          ld_mar_pc = 1'b1;
          state_d   = L_OPM;
        end
      end
      L_OPM: begin
        mem_req = 1'b1;
        if (mem_ack) begin
          ld_mbr  = 1'b1;
          inc_pc  = 1'b1;
          state_d = L_PTR;
        end else if (tmo_expired) begin
          bus_err_d = 1'b1;
          state_d   = HALTED;
        end
      end
      L_PTR: begin
        if (tick_en) begin
          ld_mar_mbr = 1'b1;
          state_d    = L_DATM;
        end
      end
      L_DATM: begin
        mem_req = 1'b1;
        if (mem_ack) begin
          ld_mbr  = 1'b1;
          state_d = L_WB;
        end else if (tmo_expired) begin
          bus_err_d = 1'b1;
          state_d   = HALTED;
        end
      end
      L_WB: begin
        if (tick_en) begin
          ld_a_mbr   = 1'b1;
          instr_done = 1'b1;
          state_d    = boundary_st;
        end
      end
      PAUSE: begin
        if (tick_en) begin
          if (!run) begin
            state_d = IDLE;
          end else if (step_req) begin
            state_d = F_ADR;
          end
        end
      end
      HALTED: begin
        state_d = HALTED;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      bus_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      bus_err_q <= bus_err_d;
    end
  end

  assign t_step  = t_step_of(state_q);
  assign busy    = !is_quiet_state(state_q);
  assign halted  = (state_q == HALTED);
  assign bus_err = bus_err_q;

endmodule

// File: tb/tb_mano_fetch_exec_sequencer.sv
// Directed self-checking bench for the fetch/execute sequencer.
// Strobe vector order: {mem_req, ld_mar_pc, ld_mar_mbr, inc_pc, ld_mbr, ld_ir, ld_a_mbr, ld_a_r, instr_done}.
module tb_mano_fetch_exec_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       tick_en;
  logic       run;
  logic       single_step;
  logic       step_req;
  logic [1:0] opcode;
  logic       mem_ack;
  logic       mem_req;
  logic       ld_mar_pc;
  logic       ld_mar_mbr;
  logic       inc_pc;
  logic       ld_mbr;
  logic       ld_ir;
  logic       ld_a_mbr;
  logic       ld_a_r;
  logic [2:0] t_step;
  logic       busy;
  logic       instr_done;
  logic       halted;
  logic       bus_err;

  int n_tests = 0;
  int n_fail  = 0;

  localparam logic [8:0] REQ = 9'h100;
  localparam logic [8:0] MPC = 9'h080;
  localparam logic [8:0] MMB = 9'h040;
  localparam logic [8:0] INC = 9'h020;
  localparam logic [8:0] MBR = 9'h010;
  localparam logic [8:0] IR  = 9'h008;
  localparam logic [8:0] AMB = 9'h004;
  localparam logic [8:0] AR  = 9'h002;
  localparam logic [8:0] DN  = 9'h001;

  always #5 clk = ~clk;

  mano_fetch_exec_sequencer #(
    .TIMEOUT_CYC (15),
    .TMO_W       (8)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .tick_en     (tick_en),
    .run         (run),
    .single_step (single_step),
    .step_req    (step_req),
    .opcode      (opcode),
    .mem_ack     (mem_ack),
    .mem_req     (mem_req),
    .ld_mar_pc   (ld_mar_pc),
    .ld_mar_mbr  (ld_mar_mbr),
    .inc_pc      (inc_pc),
    .ld_mbr      (ld_mbr),
    .ld_ir       (ld_ir),
    .ld_a_mbr    (ld_a_mbr),
    .ld_a_r      (ld_a_r),
    .t_step      (t_step),
    .busy        (busy),
    .instr_done  (instr_done),
    .halted      (halted),
    .bus_err     (bus_err)
  );

  function automatic logic [8:0] obs();
    return {mem_req, ld_mar_pc, ld_mar_mbr, inc_pc, ld_mbr, ld_ir, ld_a_mbr, ld_a_r, instr_done};
  endfunction

  task automatic next_clk();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst         = 1'b1;
    run         = 1'b0;
    single_step = 1'b0;
    step_req    = 1'b0;
    mem_ack     = 1'b0;
    tick_en     = 1'b1;
    opcode      = 2'b00;
    next_clk();
    next_clk();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    n_tests++;
    if ({obs(), t_step, busy, halted, bus_err} !== 15'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %h expected 0", {obs(), t_step, busy, halted, bus_err});
    end
    run = 1'b1; opcode = 2'b01; mem_ack = 1'b0;
    next_clk();
    next_clk();
    mem_ack = 1'b1;
    next_clk();
    mem_ack = 1'b0;
    next_clk();
    next_clk();
    #1;
    n_tests++;
    if (mem_req !== 1'b1 || t_step !== 3'd4) begin
      n_fail++;
      $display("FAIL reset_reach_lopm: got req=%b t=%0d expected req=1 t=4", mem_req, t_step);
    end
    rst = 1'b1;
    #1;
    n_tests++;
    if ({obs(), t_step, busy, halted, bus_err} !== 15'd0) begin
      n_fail++;
      $display("FAIL reset_async_midwait: got %h expected 0", {obs(), t_step, busy, halted, bus_err});
    end
    next_clk();
    rst = 1'b0;
  endtask

  task automatic test_movr();
    logic [8:0] e  [0:4];
    logic [2:0] ts [0:4];
    e  = '{MPC, REQ | MBR | INC, IR, AR | DN, MPC};
    ts = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd0};
    do_reset();
    run = 1'b1; opcode = 2'b10; mem_ack = 1'b1;
    next_clk();
    for (int i = 0; i < 5; i++) begin
      #1;
      n_tests++;
      if (obs() !== e[i] || t_step !== ts[i] || busy !== 1'b1) begin
        n_fail++;
        $display("FAIL movr_step[%0d]: got strobes=%h t=%0d busy=%b expected strobes=%h t=%0d busy=1",
                 i, obs(), t_step, busy, e[i], ts[i]);
      end
      next_clk();
    end
  endtask

  task automatic test_lda_delayed();
    logic [8:0] e   [0:14];
    logic [2:0] ts  [0:14];
    logic       ack [0:14];
    int         inc_cnt;
    int         mmb_cnt;
    e   = '{MPC, REQ, REQ, REQ | MBR | INC, IR, MPC, REQ, REQ, REQ | MBR | INC,
            MMB, REQ, REQ, REQ | MBR, AMB | DN, 9'h000};
    ts  = '{3'd0, 3'd1, 3'd1, 3'd1, 3'd2, 3'd3, 3'd4, 3'd4, 3'd4,
            3'd5, 3'd6, 3'd6, 3'd6, 3'd7, 3'd0};
    ack = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1,
            1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    inc_cnt = 0;
    mmb_cnt = 0;
    do_reset();
    run = 1'b1; opcode = 2'b01;
    next_clk();
    for (int i = 0; i < 15; i++) begin
      mem_ack = ack[i];
      if (i == 6) run = 1'b0;
      #1;
      if (inc_pc) inc_cnt++;
      if (ld_mar_mbr) mmb_cnt++;
      n_tests++;
      if (obs() !== e[i] || t_step !== ts[i]) begin
        n_fail++;
        $display("FAIL lda_step[%0d]: got strobes=%h t=%0d expected strobes=%h t=%0d",
                 i, obs(), t_step, e[i], ts[i]);
      end
      next_clk();
    end
    mem_ack = 1'b0;
    n_tests++;
    if (inc_cnt != 2 || mmb_cnt != 1) begin
      n_fail++;
      $display("FAIL lda_counts: got inc_pc=%0d ld_mar_mbr=%0d expected 2 and 1", inc_cnt, mmb_cnt);
    end
    n_tests++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL lda_stop_at_boundary: got busy=%b expected 0", busy);
    end
  endtask

  task automatic test_timeout();
    int req_cnt;
    int mbr_cnt;
    req_cnt = 0;
    mbr_cnt = 0;
    do_reset();
    run = 1'b1; opcode = 2'b00; mem_ack = 1'b0;
    next_clk();
    next_clk();
    for (int i = 0; i < 20; i++) begin
      #1;
      if (mem_req) req_cnt++;
      if (ld_mbr) mbr_cnt++;
      next_clk();
    end
    n_tests++;
    if (req_cnt != 15 || mbr_cnt != 0) begin
      n_fail++;
      $display("FAIL timeout_req_len: got req_clks=%0d ld_mbr=%0d expected 15 and 0", req_cnt, mbr_cnt);
    end
    n_tests++;
    if (bus_err !== 1'b1 || halted !== 1'b1 || mem_req !== 1'b0) begin
      n_fail++;
      $display("FAIL timeout_flags: got bus_err=%b halted=%b req=%b expected 1 1 0", bus_err, halted, mem_req);
    end

    req_cnt = 0;
    mbr_cnt = 0;
    do_reset();
    n_tests++;
    if (bus_err !== 1'b0) begin
      n_fail++;
      $display("FAIL bus_err_cleared_by_rst: got %b expected 0", bus_err);
    end
    run = 1'b1; opcode = 2'b00; mem_ack = 1'b0;
    next_clk();
    next_clk();
    for (int i = 0; i < 15; i++) begin
      mem_ack = (i == 14);
      #1;
      if (mem_req) req_cnt++;
      if (ld_mbr) mbr_cnt++;
      next_clk();
    end
    mem_ack = 1'b0;
    #1;
    n_tests++;
    if (req_cnt != 15 || mbr_cnt != 1) begin
      n_fail++;
      $display("FAIL late_ack_counts: got req_clks=%0d ld_mbr=%0d expected 15 and 1", req_cnt, mbr_cnt);
    end
    n_tests++;
    if (bus_err !== 1'b0 || halted !== 1'b0 || t_step !== 3'd2) begin
      n_fail++;
      $display("FAIL late_ack_wins: got bus_err=%b halted=%b t=%0d expected 0 0 2", bus_err, halted, t_step);
    end
  endtask

  task automatic test_single_step();
    logic [8:0] e [0:2];
    e = '{MPC, REQ | MBR | INC, IR | DN};
    do_reset();
    run = 1'b1; single_step = 1'b1; opcode = 2'b00; mem_ack = 1'b1;
    next_clk();
    for (int i = 0; i < 3; i++) begin
      #1;
      n_tests++;
      if (obs() !== e[i]) begin
        n_fail++;
        $display("FAIL step_first_nop[%0d]: got %h expected %h", i, obs(), e[i]);
      end
      next_clk();
    end
    for (int i = 0; i < 3; i++) begin
      #1;
      n_tests++;
      if (busy !== 1'b0 || obs() !== 9'h000 || t_step !== 3'd0) begin
        n_fail++;
        $display("FAIL step_paused[%0d]: got busy=%b strobes=%h t=%0d expected 0 0 0", i, busy, obs(), t_step);
      end
      next_clk();
    end
    step_req = 1'b1;
    next_clk();
    for (int i = 0; i < 3; i++) begin
      step_req = (i == 0);
      #1;
      n_tests++;
      if (obs() !== e[i] || busy !== 1'b1) begin
        n_fail++;
        $display("FAIL step_released_nop[%0d]: got strobes=%h busy=%b expected %h busy=1", i, obs(), busy, e[i]);
      end
      next_clk();
    end
    step_req = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      n_tests++;
      if (busy !== 1'b0) begin
        n_fail++;
        $display("FAIL step_req_not_queued[%0d]: got busy=%b expected 0", i, busy);
      end
      next_clk();
    end
    run = 1'b0;
    next_clk();
    run = 1'b1;
    #1;
    n_tests++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL pause_to_idle: got busy=%b expected 0", busy);
    end
    next_clk();
    #1;
    n_tests++;
    if (busy !== 1'b1 || obs() !== MPC) begin
      n_fail++;
      $display("FAIL idle_restart: got busy=%b strobes=%h expected 1 %h", busy, obs(), MPC);
    end
    single_step = 1'b0;
  endtask

  task automatic test_halt_tick();
    logic [8:0] e  [0:8];
    logic [2:0] ts [0:8];
    logic [8:0] exp_o;
    logic [2:0] exp_t;
    logic       exp_h;
    e  = '{9'h000, 9'h000, 9'h000, 9'h000, MPC, REQ | MBR | INC, 9'h000, 9'h000, IR | DN};
    ts = '{3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd1, 3'd2, 3'd2, 3'd2};
    do_reset();
    run = 1'b1; opcode = 2'b11; mem_ack = 1'b1;
    for (int k = 0; k < 25; k++) begin
      tick_en = (k % 4 == 0);
      if (k >= 9) begin
        run      = k[0];
        step_req = (k % 3 == 0);
      end
      exp_o = (k < 9) ? e[k] : 9'h000;
      exp_t = (k < 9) ? ts[k] : 3'd0;
      exp_h = (k >= 9);
      #1;
      n_tests++;
      if (obs() !== exp_o || t_step !== exp_t || halted !== exp_h || bus_err !== 1'b0) begin
        n_fail++;
        $display("FAIL halt_tick[%0d]: got strobes=%h t=%0d halted=%b bus_err=%b expected %h t=%0d halted=%b bus_err=0",
                 k, obs(), t_step, halted, bus_err, exp_o, exp_t, exp_h);
      end
      next_clk();
    end
    step_req = 1'b0;
    tick_en  = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_movr();
    test_lda_delayed();
    test_timeout();
    test_single_step();
    test_halt_tick();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mano_fetch_exec_sequencer.md
Name: mano_fetch_exec_sequencer

Overview:
- Synchronous control sequencer for the accumulator computer datapath (PC, MAR, MBR, IR, A, R and the byte-wide memory).
- It replaces free-running T-step decoding with a single-clock FSM. The FSM issues one-cycle load/increment strobes to the datapath and handshakes with memory.
- It supports run/stop, single-instruction stepping and a memory timeout. It sits between the top-level user inputs and the datapath register file.

Parameters:
- TIMEOUT_CYC, 15, clocks to wait for mem_ack before flagging a bus error (1..255)
- TMO_W, 8, width of the timeout counter; must satisfy TIMEOUT_CYC < 2**TMO_W

Ports:
- clk  input  1  system clock; all state changes on its rising edge
- rst  input  1  asynchronous, active-high reset
- tick_en  input  1  advance qualifier from the clock divider; FSM steps only when high, except in memory-wait states
- run  input  1  level; 1 = execute instructions, 0 = stop at the next instruction boundary
- single_step  input  1  level; 1 = pause after every instruction
- step_req  input  1  one-clk pulse; releases one instruction from PAUSE
- opcode  input  2  IR[1:0] from datapath; 00 NOP, 01 LDA, 10 MOVR, 11 HLT
- mem_ack  input  1  memory read data valid this clk
- mem_req  output  1  memory read request; held until mem_ack or timeout
- ld_mar_pc  output  1  MAR <= PC strobe
- ld_mar_mbr  output  1  MAR <= MBR strobe
- inc_pc  output  1  PC <= PC+1 strobe
- ld_mbr  output  1  MBR <= mem[MAR] strobe
- ld_ir  output  1  IR <= MBR strobe
- ld_a_mbr  output  1  A <= MBR strobe
- ld_a_r  output  1  A <= R strobe
- t_step  output  3  index of the current micro-step within the instruction (0..7)
- busy  output  1  high in every state except IDLE, PAUSE, HALTED
- instr_done  output  1  one-clk pulse on completion of each instruction
- halted  output  1  high in HALTED
- bus_err  output  1  sticky timeout flag; cleared only by rst

Behaviour:
- Reset (async, any state, including mid-memory-wait):
  - state = IDLE; all strobes, mem_req, instr_done, halted and bus_err = 0; t_step = 0; timeout counter = 0.
- Strobes are Moore-decoded from state and gated by the advance condition, so each pulses for exactly one clk. At most one MAR source and one A source is active in any clk.
- States, with the action on the advancing clk:
  - IDLE: if run, go to F_ADR.
  - F_ADR (t0): ld_mar_pc; go to F_MEM.
  - F_MEM (t1): mem_req. When mem_ack: ld_mbr, inc_pc, go to DEC.
  - DEC (t2): ld_ir; then dispatch on opcode:
    - 00 -> DONE
    - 01 -> L_ADR
    - 10 -> X_MOV
    - 11 -> HALTED (instr_done pulses)
  - X_MOV (t3): ld_a_r; go to DONE.
  - L_ADR (t3): ld_mar_pc; go to L_OPM.
  - L_OPM (t4): mem_req. When ack: ld_mbr, inc_pc, go to L_PTR.
  - L_PTR (t5): ld_mar_mbr; go to L_DATM.
  - L_DATM (t6): mem_req. When ack: ld_mbr (no inc_pc), go to L_WB.
  - L_WB (t7): ld_a_mbr; go to DONE.
  - DONE: instr_done pulses; this state is zero-time, folded into the transition. Next state:
    - if !run -> IDLE
    - else if single_step -> PAUSE
    - else -> F_ADR
  - PAUSE: on step_req with run = 1, go to F_ADR. If run drops, go to IDLE.
  - HALTED: terminal until rst. run, step_req and tick_en are ignored.
- tick_en gating:
  - Non-memory states advance only on clks with tick_en = 1.
  - Memory states (F_MEM, L_OPM, L_DATM) sample mem_ack every clk regardless of tick_en.
  - mem_req may be acked in the same clk it first asserts.
- Timeout:
  - Counter clears on entry to a memory state and increments each clk without ack.
  - On reaching TIMEOUT_CYC: set bus_err, drop mem_req, go to HALTED; no ld_mbr.
  - An ack arriving in the same clk as the terminal count wins: normal completion, no error.
- Cycle counts (tick_en = 1, ack in first clk), F_ADR to completion:
  - NOP 3 clks
  - MOVR 4 clks
  - LDA 8 clks
  - HLT 3 clks, then halted.
- run deassertion mid-instruction: the instruction completes; the FSM stops at the boundary.
- step_req outside PAUSE is ignored (not queued).
- t_step holds its value while stalled; it is 0 in IDLE, PAUSE and HALTED.

Decomposition:
- Shared package holds:
  - state enum (IDLE, F_ADR, F_MEM, DEC, X_MOV, L_ADR, L_OPM, L_PTR, L_DATM, L_WB, PAUSE, HALTED)
  - opcode constants OP_NOP/OP_LDA/OP_MOVR/OP_HLT
  - default TIMEOUT_CYC
- One sub-module: mano_mem_wait_timer. It takes clear, count enable and ack; it outputs expired. It is instantiated once and shared by the three memory states.

Test Plan:
- rst pulse mid-L_OPM with mem_req high -> same clk: mem_req = 0, state IDLE, all outputs 0, bus_err 0.
- run = 1, opcode = 10, immediate ack, tick_en = 1 -> strobes in order ld_mar_pc, ld_mbr+inc_pc, ld_ir, ld_a_r; instr_done in the 4th clk; then F_ADR.
- opcode = 01, ack delayed 3 clks on every read -> inc_pc exactly twice, ld_mar_mbr once, ld_a_mbr in the 8th advancing step; total 14 clks.
- No ack with TIMEOUT_CYC = 15 -> mem_req high 15 clks, then bus_err = 1, halted = 1, ld_mbr never pulses. Repeat with ack on clk 15 -> no error.
- single_step = 1, opcode = 00 -> PAUSE after 3 clks. step_req pulse -> exactly one more NOP, then PAUSE. step_req while busy -> ignored.
- tick_en high 1 clk in 4, opcode = 11 -> non-memory steps advance only on tick clks; halted stays set; run toggling and step_req do not exit HALTED.
